tile_addr_sched: RTL and testbench

- Sequences the row (A-operand) and column (B-operand) read-address streams that feed the systolic tensor-core array.
- For each tile job it accepts a configuration and computes the packed word count for the selected precision.
- It then issues one row/column address pair per un-stalled cycle and marks the first and last beats. After the systolic skew drains, it reports completion.
- It sits between the tile-level command issuer and the row/column edge address units of the array.

---
 rtl/tile_addr_sched_pkg.sv | 31 +++
 rtl/tile_addr_sched_cnt.sv | 69 ++++++
 rtl/tile_addr_sched.sv | 160 ++++++++++++++++
 tb/tb_tile_addr_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_addr_sched_pkg.sv
// Shared types for the tensor-core tile address scheduler: operand precision,
// scheduler states and the precision-to-pack-shift mapping.
package tc_pkg;

    typedef enum logic [1:0] {
        PREC_FP32 = 2'b00,
        PREC_FP16 = 2'b01,
        PREC_INT8 = 2'b10,
        PREC_INT4 = 2'b11
    } prec_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } sched_state_e;

    // log2 of the number of elements packed into one buffer word
    function automatic logic [1:0] pack_shift(input prec_e prec);
        case (prec)
            PREC_FP32: return 2'd0;
            PREC_FP16: return 2'd1;
            PREC_INT8: return 2'd2;
            PREC_INT4: return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/tile_addr_sched_cnt.sv
// One operand address stream: latched base plus a beat index, producing the
// registered wrapped address, strobe and first/last markers.
module tile_addr_cnt #(
    parameter int ADDR_W = 10,
    parameter int K_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              base_ld,
    input  logic [ADDR_W-1:0] base_in,
    input  logic              clr,
    input  logic              adv,
    input  logic [K_W:0]      words,
    output logic              en_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              first_o,
    output logic              last_o,
    output logic              last_beat
);

    localparam logic [K_W:0] ONE_W = (K_W+1)'(1);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [K_W:0]      idx_q, idx_d, idx_cur;
    logic              en_q, en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              first_q, first_d;
    logic              last_q, last_d;

    // clr takes effect in the same cycle so the very first beat can issue
    // on the cycle the index is being cleared
    assign idx_cur   = clr ? '0 : idx_q;
    assign last_beat = (idx_cur == words - ONE_W);

    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        base_d  = base_ld ? base_in : base_q;
        idx_d   = adv ? idx_cur + ONE_W : idx_cur;
        en_d    = adv;
        first_d = adv && (idx_cur == '0);
        last_d  = adv && last_beat;
        addr_d  = adv ? base_q + idx_cur[ADDR_W-1:0] : addr_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q  <= '0;
            idx_q   <= '0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            base_q  <= base_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign en_o    = en_q;
    assign addr_o  = addr_q;
    assign first_o = first_q;
    assign last_o  = last_q;

endmodule

// File: rtl/tile_addr_sched.sv
// Tile address scheduler: accepts a tile job, streams lock-stepped row/column
// read addresses for the packed word count, then waits out the systolic skew.
module tile_addr_sched
    import tc_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int K_W     = 12,
    parameter int ARRAY_N = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_prec,
    input  logic [K_W-1:0]    cfg_k,
    input  logic [ADDR_W-1:0] cfg_row_base,
    input  logic [ADDR_W-1:0] cfg_col_base,
    input  logic              stall,
    output logic              row_en,
    output logic [ADDR_W-1:0] row_addr,
    output logic              col_en,
    output logic [ADDR_W-1:0] col_addr,
    output logic              beat_first,
    output logic              beat_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                 DRAIN_W    = $clog2(2 * ARRAY_N);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(2 * ARRAY_N - 1);
    localparam logic [K_W:0]       ONE_W      = (K_W+1)'(1);

    sched_state_e       state_q, state_d;
    prec_e              prec_q, prec_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [K_W:0]       words_q, words_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               in_load, issue, base_ld;
    logic [1:0]         shift;
    logic [K_W:0]       round_up, words_calc, words_cur;
    logic               row_last_beat, col_last_beat, last_beat;
    logic               row_first, col_first, row_last, col_last;

    assign cfg_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

    // ceil(k / P) at one extra bit so k near full scale cannot overflow
    assign shift      = pack_shift(prec_q);
    assign round_up   = {1'b0, k_q} + ((ONE_W << shift) - ONE_W);
    assign words_calc = round_up >> shift;

    // LOAD already issues beat 0, so it uses the freshly computed word count
    assign in_load   = (state_q == ST_LOAD);
    assign words_cur = in_load ? words_calc : words_q;
    assign issue     = (in_load || state_q == ST_STREAM) && !stall;
    assign base_ld   = cfg_ready && cfg_valid && (cfg_k != '0);
    assign last_beat = row_last_beat && col_last_beat;

    always_comb begin
        state_d = state_q;
        prec_d  = prec_q;
        k_d     = k_q;
        words_d = words_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_k == '0) begin
                        err_d = 1'b1;
                    end else begin
                        prec_d  = prec_e'(cfg_prec);
                        k_d     = cfg_k;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD, ST_STREAM: begin
                words_d = words_cur;
                if (in_load) state_d = ST_STREAM;
                if (issue && last_beat) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            prec_q  <= PREC_FP32;
            k_q     <= '0;
            words_q <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prec_q  <= prec_d;
            k_q     <= k_d;
            words_q <= words_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    tile_addr_cnt #(.ADDR_W(ADDR_W), .K_W(K_W)) u_row (
        .clk       (clk),
        .rst       (rst),
        .base_ld   (base_ld),
        .base_in   (cfg_row_base),
        .clr       (in_load),
        .adv       (issue),
        .words     (words_cur),
        .en_o      (row_en),
        .addr_o    (row_addr),
        .first_o   (row_first),
        .last_o    (row_last),
        .last_beat (row_last_beat)
    );

    tile_addr_cnt #(.ADDR_W(ADDR_W), .K_W(K_W)) u_col (
        .clk       (clk),
        .rst       (rst),
        .base_ld   (base_ld),
        .base_in   (cfg_col_base),
        .clr       (in_load),
        .adv       (issue),
        .words     (words_cur),
        .en_o      (col_en),
        .addr_o    (col_addr),
        .first_o   (col_first),
        .last_o    (col_last),
        .last_beat (col_last_beat)
    );

    // both streams advance in lock-step, so their markers always agree
    assign beat_first = row_first && col_first;
    assign beat_last  = row_last && col_last;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_tile_addr_sched.sv
// Self-checking bench for tile_addr_sched: directed jobs plus random jobs under
// random stall, checked against a transaction-level beat model.
module tb_tile_addr_sched;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_prec;
    logic [11:0] cfg_k;
    logic [9:0]  cfg_row_base;
    logic [9:0]  cfg_col_base;
    logic        stall;
    logic        row_en;
    logic [9:0]  row_addr;
    logic        col_en;
    logic [9:0]  col_addr;
    logic        beat_first;
    logic        beat_last;
    logic        busy;
    logic        done;
    logic        err;

    tile_addr_sched dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_prec     (cfg_prec),
        .cfg_k        (cfg_k),
        .cfg_row_base (cfg_row_base),
        .cfg_col_base (cfg_col_base),
        .stall        (stall),
        .row_en       (row_en),
        .row_addr     (row_addr),
        .col_en       (col_en),
        .col_addr     (col_addr),
        .beat_first   (beat_first),
        .beat_last    (beat_last),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] ra;
        logic [9:0] ca;
        logic       f;
        logic       l;
        int         c;
    } beat_t;

    beat_t beats[$];
    int    cyc = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    int    err_cycles = 0;
    int    hold_viol = 0;
    int    strobe_bad = 0;
    logic [9:0] prev_ra = '0;
    logic [9:0] prev_ca = '0;
    int    n_total = 0;
    int    n_pass = 0;
    int    acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation of the output streams, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            prev_ra <= '0;
            prev_ca <= '0;
        end else begin
            if (row_en) beats.push_back('{row_addr, col_addr, beat_first, beat_last, cyc});
            if (row_en !== col_en) strobe_bad <= strobe_bad + 1;
            if (!row_en && (row_addr !== prev_ra || col_addr !== prev_ca)) hold_viol <= hold_viol + 1;
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (err) err_cycles <= err_cycles + 1;
            prev_ra <= row_addr;
            prev_ca <= col_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: elements per word by precision, words rounded up
    function automatic int exp_words(input logic [1:0] prec, input int k);
        int p;
        int w;
        case (prec)
            2'b00:   p = 1;
            2'b01:   p = 2;
            2'b10:   p = 4;
            default: p = 8;
        endcase
        w = k / p;
        if (k % p != 0) w = w + 1;
        return w;
    endfunction

    task automatic start_job(input logic [1:0] prec, input int k, input logic [9:0] rb, input logic [9:0] cb);
        beats.delete();
        done_cnt     = 0;
        cfg_prec     = prec;
        cfg_k        = k[11:0];
        cfg_row_base = rb;
        cfg_col_base = cb;
        cfg_valid    = 1'b1;
        stall        = 1'b0;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        acc_cyc   = cyc;
    endtask

    task automatic run_job(input string tag, input logic [1:0] prec, input int k,
                           input logic [9:0] rb, input logic [9:0] cb,
                           input int stall_pct, input bit stall_after2, input bit inject);
        int  w;
        int  stall_left;
        bit  did_stall;
        bit  did_inject;
        stall_left = 0;
        did_stall  = 1'b0;
        did_inject = 1'b0;
        start_job(prec, k, rb, cb);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            stall     = 1'b0;
            cfg_valid = 1'b0;
            if (stall_after2 && row_en && beats.size() == 2 && !did_stall) begin
                stall_left = 3;
                did_stall  = 1'b1;
            end
            if (stall_left > 0) begin
                stall      = 1'b1;
                stall_left = stall_left - 1;
            end else if (stall_pct > 0) begin
                stall = ($urandom_range(99) < stall_pct);
            end
            if (inject && beats.size() == 1 && !did_inject) begin
                cfg_valid  = 1'b1;
                cfg_k      = 12'd0;
                did_inject = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        stall     = 1'b0;
        cfg_valid = 1'b0;

        w = exp_words(prec, k);
        check({tag, ".done_cnt"}, done_cnt, 1);
        check({tag, ".beats"}, beats.size(), w);
        for (int i = 0; i < beats.size() && i < w; i++) begin
            check($sformatf("%s.row_addr[%0d]", tag, i), beats[i].ra, (int'(rb) + i) % 1024);
            check($sformatf("%s.col_addr[%0d]", tag, i), beats[i].ca, (int'(cb) + i) % 1024);
            check($sformatf("%s.first[%0d]", tag, i), beats[i].f, (i == 0));
            check($sformatf("%s.last[%0d]", tag, i), beats[i].l, (i == w - 1));
        end
        if (beats.size() > 0) check({tag, ".done_lat"}, done_cyc - beats[$].c, 16);
        check({tag, ".busy_after"}, busy, 0);
        check({tag, ".ready_after"}, cfg_ready, 1);
    endtask

    initial begin
        rst          = 1'b0;
        cfg_valid    = 1'b0;
        cfg_prec     = 2'b00;
        cfg_k        = '0;
        cfg_row_base = '0;
        cfg_col_base = '0;
        stall        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.row_en", row_en, 0);
        check("rst.col_en", col_en, 0);
        check("rst.row_addr", row_addr, 0);
        check("rst.col_addr", col_addr, 0);
        check("rst.first_last", {beat_first, beat_last}, 0);
        check("rst.done_err", {done, err}, 0);
        check("rst.busy", busy, 0);
        check("rst.ready", cfg_ready, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic FP32 job, no stall, with first-beat latency
        run_job("t1", 2'b00, 4, 10'h010, 10'h020, 0, 1'b0, 1'b0);
        if (beats.size() > 0) check("t1.first_lat", beats[0].c - acc_cyc, 1);

        // 2: packing per precision
        run_job("t2_fp16", 2'b01, 5, 10'h040, 10'h080, 0, 1'b0, 1'b0);
        run_job("t2_int8", 2'b10, 9, 10'h100, 10'h140, 0, 1'b0, 1'b0);
        run_job("t2_int4", 2'b11, 16, 10'h200, 10'h240, 0, 1'b0, 1'b0);
        run_job("t2_int4k1", 2'b11, 1, 10'h300, 10'h310, 0, 1'b0, 1'b0);

        // 3: three-cycle stall after beat 2
        run_job("t3", 2'b00, 6, 10'h050, 10'h060, 0, 1'b1, 1'b0);
        if (beats.size() > 3) check("t3.stall_gap", beats[3].c - beats[2].c, 4);

        // 4: address wrap-around
        run_job("t4", 2'b00, 4, 10'h3FE, 10'h3FD, 0, 1'b0, 1'b0);

        // 5: zero-length job rejected, then a cfg pulse during STREAM is ignored
        beats.delete();
        done_cnt     = 0;
        cfg_k        = 12'd0;
        cfg_valid    = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        check("t5.err_pulse", err, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5.ready[%0d]", i), cfg_ready, 1);
            @(posedge clk);
            #1;
        end
        check("t5.err_cycles", err_cycles, 1);
        check("t5.no_beats", beats.size(), 0);
        check("t5.no_done", done_cnt, 0);
        run_job("t5_inject", 2'b00, 5, 10'h0A0, 10'h0B0, 0, 1'b0, 1'b1);
        check("t5.err_after_inject", err_cycles, 1);

        // 6: reset mid-stream, then a fresh job
        start_job(2'b00, 8, 10'h111, 10'h222);
        for (int i = 0; i < 50 && !(row_en && beats.size() == 1); i++) begin
            @(posedge clk);
            #1;
        end
        check("t6.reached_beat1", beats.size(), 1);
        rst = 1'b0;
        #1;
        check("t6.row_en", row_en, 0);
        check("t6.col_en", col_en, 0);
        check("t6.addrs", {row_addr, col_addr}, 0);
        check("t6.flags", {beat_first, beat_last, done, err}, 0);
        check("t6.busy", busy, 0);
        check("t6.ready", cfg_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("t6.no_done", done_cnt, 0);
        check("t6.idle", busy, 0);
        run_job("t6_after", 2'b00, 2, 10'h111, 10'h222, 0, 1'b0, 1'b0);

        // Random jobs under random stall
        for (int j = 0; j < 10; j++) begin
            logic [1:0] p;
            int         k;
            logic [9:0] rb;
            logic [9:0] cb;
            p  = 2'($urandom_range(3));
            k  = $urandom_range(1, 40);
            rb = 10'($urandom_range(1023));
            cb = 10'($urandom_range(1023));
            run_job($sformatf("rnd%0d", j), p, k, rb, cb, 30, 1'b0, 1'b0);
        end

        check("global.addr_hold", hold_viol, 0);
        check("global.strobe_match", strobe_bad, 0);
        check("global.err_cycles", err_cycles, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
